dcache_port_arbiter: RTL and testbench

- Shares the single data-cache port between two requesters:
  - the load path from the LSU;
  - the store-buffer drain.
- Grants one transaction at a time and latches the winner's payload.
- Sequences the dcache request/ack handshake and routes the ack and read data back to the owner.
- Loads take priority for latency, with a starvation guard so committed stores always drain; stores also win when the store buffer is full or in finish/drain mode.

---
 rtl/params_pkg.sv | 21 ++
 rtl/dcache_port_arbiter.sv | 132 +++++++++++++
 tb/tb_dcache_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/params_pkg.sv
// Shared types for the data-cache port arbitration slice.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// access_size_t : access width carried with every dcache transaction.
// arb_state_t   : ownership state of the single dcache port.
package params_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } access_size_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_BUSY  = 2'd1,
    STORE_BUSY = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dcache_port_arbiter.sv
// Shares one dcache port between the LSU load path and the store-buffer drain.
// Latency: request seen in cycle N drives dc_req_o in N+1; ack is passed through combinationally.
// Backpressure: requesters hold req+payload until their ack; one IDLE bubble between transactions.
//
// Ports:
//   clk_i / rst_i              clock, asynchronous active-low reset
//   load_*                     load requester: req/addr/size in, ack/data out
//   sb_store_*, sb_full_i,     store-buffer requester: req/addr/data/size in, ack out,
//   sb_drain_i                 plus full / finish-mode hints that force store priority
//   dc_*                       dcache request side: req/we/addr/wdata/size out, ack/rdata in
//   busy_o                     a transaction is outstanding
module dcache_port_arbiter
  import params_pkg::*;
#(
  parameter int ADDR_WIDTH       = 32,
  parameter int DATA_WIDTH       = 32,
  parameter int STARVE_LIMIT     = 4,
  parameter int STARVE_CNT_WIDTH = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  load_req_i,
  input  logic [ADDR_WIDTH-1:0] load_addr_i,
  input  access_size_t          load_size_i,
  output logic                  load_ack_o,
  output logic [DATA_WIDTH-1:0] load_data_o,

  input  logic                  sb_store_req_i,
  input  logic [ADDR_WIDTH-1:0] sb_store_addr_i,
  input  logic [DATA_WIDTH-1:0] sb_store_data_i,
  input  access_size_t          sb_store_size_i,
  output logic                  sb_store_ack_o,
  input  logic                  sb_full_i,
  input  logic                  sb_drain_i,

  output logic                  dc_req_o,
  output logic                  dc_we_o,
  output logic [ADDR_WIDTH-1:0] dc_addr_o,
  output logic [DATA_WIDTH-1:0] dc_wdata_o,
  output access_size_t          dc_size_o,
  input  logic                  dc_ack_i,
  input  logic [DATA_WIDTH-1:0] dc_rdata_i,

  output logic                  busy_o
);

  // STARVE_CNT_WIDTH must be wide enough to represent STARVE_LIMIT itself.
  localparam logic [STARVE_CNT_WIDTH-1:0] STARVE_MAX = STARVE_CNT_WIDTH'(STARVE_LIMIT);

  arb_state_t                  state_q;
  logic [STARVE_CNT_WIDTH-1:0] starve_cnt_q;
  logic                        we_q;
  logic [ADDR_WIDTH-1:0]       addr_q;
  logic [DATA_WIDTH-1:0]       wdata_q;
  access_size_t                size_q;
  logic [DATA_WIDTH-1:0]       rdata_q;

  logic store_wins;
  logic load_wins;
  logic load_done;
  logic store_done;

  // Loads are preferred; a waiting store takes the port when the buffer is
  // under pressure, when loads have starved it long enough, or when no load
  // is competing.
  assign store_wins = sb_store_req_i &&
                      (sb_full_i || sb_drain_i || (starve_cnt_q >= STARVE_MAX) || !load_req_i);
  assign load_wins  = !store_wins && load_req_i;

  assign load_done  = (state_q == LOAD_BUSY)  && dc_ack_i;
  assign store_done = (state_q == STORE_BUSY) && dc_ack_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= WORD;
      rdata_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (store_wins) begin
            state_q      <= STORE_BUSY;
            we_q         <= 1'b1;
            addr_q       <= sb_store_addr_i;
            wdata_q      <= sb_store_data_i;
            size_q       <= sb_store_size_i;
            starve_cnt_q <= '0;
          end else if (load_wins) begin
            // Write data is left untouched on a load grant.
            state_q <= LOAD_BUSY;
            we_q    <= 1'b0;
            addr_q  <= load_addr_i;
            size_q  <= load_size_i;
            if (sb_store_req_i && (starve_cnt_q < STARVE_MAX)) begin
              starve_cnt_q <= starve_cnt_q + 1'b1;
            end
          end
        end
        LOAD_BUSY: begin
          if (dc_ack_i) begin
            state_q <= IDLE;
            rdata_q <= dc_rdata_i;
          end
        end
        STORE_BUSY: begin
          if (dc_ack_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dc_req_o       = (state_q != IDLE);
  assign busy_o         = (state_q != IDLE);
  assign dc_we_o        = we_q;
  assign dc_addr_o      = addr_q;
  assign dc_wdata_o     = wdata_q;
  assign dc_size_o      = size_q;

  // Read data is forwarded in the ack cycle; afterwards the last read value is held.
  assign load_ack_o     = load_done;
  assign load_data_o    = load_done ? dc_rdata_i : rdata_q;
  assign sb_store_ack_o = store_done;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Self-checking bench for dcache_port_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
// Inputs change 1 time unit after posedge; outputs are sampled 4 units after posedge.
`timescale 1ns/1ps
module tb_dcache_port_arbiter;
  import params_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SL = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          load_req_i;
  logic [AW-1:0] load_addr_i;
  access_size_t  load_size_i;
  logic          load_ack_o;
  logic [DW-1:0] load_data_o;
  logic          sb_store_req_i;
  logic [AW-1:0] sb_store_addr_i;
  logic [DW-1:0] sb_store_data_i;
  access_size_t  sb_store_size_i;
  logic          sb_store_ack_o;
  logic          sb_full_i;
  logic          sb_drain_i;
  logic          dc_req_o;
  logic          dc_we_o;
  logic [AW-1:0] dc_addr_o;
  logic [DW-1:0] dc_wdata_o;
  access_size_t  dc_size_o;
  logic          dc_ack_i;
  logic [DW-1:0] dc_rdata_i;
  logic          busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  dcache_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL), .STARVE_CNT_WIDTH(3)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .load_req_i(load_req_i), .load_addr_i(load_addr_i), .load_size_i(load_size_i),
    .load_ack_o(load_ack_o), .load_data_o(load_data_o),
    .sb_store_req_i(sb_store_req_i), .sb_store_addr_i(sb_store_addr_i),
    .sb_store_data_i(sb_store_data_i), .sb_store_size_i(sb_store_size_i),
    .sb_store_ack_o(sb_store_ack_o), .sb_full_i(sb_full_i), .sb_drain_i(sb_drain_i),
    .dc_req_o(dc_req_o), .dc_we_o(dc_we_o), .dc_addr_o(dc_addr_o),
    .dc_wdata_o(dc_wdata_o), .dc_size_o(dc_size_o),
    .dc_ack_i(dc_ack_i), .dc_rdata_i(dc_rdata_i), .busy_o(busy_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic look();
    #3;
  endtask

  task automatic idle_inputs();
    load_req_i = 0; load_addr_i = '0; load_size_i = WORD;
    sb_store_req_i = 0; sb_store_addr_i = '0; sb_store_data_i = '0; sb_store_size_i = WORD;
    sb_full_i = 0; sb_drain_i = 0; dc_ack_i = 0; dc_rdata_i = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_i = 0;
    tick(); tick();
    rst_i = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 0;
    load_req_i = 1; sb_store_req_i = 1; dc_ack_i = 1;
    tick(); tick(); look();
    checks++; if (dc_req_o !== 1'b0) begin errors++; $display("FAIL reset_dc_req got %b want 0", dc_req_o); end
    checks++; if (dc_we_o !== 1'b0) begin errors++; $display("FAIL reset_dc_we got %b want 0", dc_we_o); end
    checks++; if (load_ack_o !== 1'b0 || sb_store_ack_o !== 1'b0) begin errors++; $display("FAIL reset_acks got %b%b want 00", load_ack_o, sb_store_ack_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
    checks++; if (dc_addr_o !== '0 || dc_wdata_o !== '0 || load_data_o !== '0) begin errors++; $display("FAIL reset_data addr %h wdata %h ldata %h want 0", dc_addr_o, dc_wdata_o, load_data_o); end
    checks++; if (dc_size_o !== WORD) begin errors++; $display("FAIL reset_size got %0d want %0d", dc_size_o, WORD); end
    idle_inputs();
    tick();
    rst_i = 1;
  endtask

  task automatic test_single_load();
    apply_reset();
    load_req_i = 1; load_addr_i = 32'h100; load_size_i = WORD;
    look();
    checks++; if (dc_req_o !== 1'b0) begin errors++; $display("FAIL single_cycle0_req got %b want 0", dc_req_o); end
    tick(); look();
    checks++; if (dc_req_o !== 1'b1 || dc_we_o !== 1'b0) begin errors++; $display("FAIL single_cycle1 req/we got %b/%b want 1/0", dc_req_o, dc_we_o); end
    checks++; if (dc_addr_o !== 32'h100 || dc_size_o !== WORD) begin errors++; $display("FAIL single_payload addr %h size %0d want 100/%0d", dc_addr_o, dc_size_o, WORD); end
    tick(); tick(); look();
    checks++; if (load_ack_o !== 1'b0 || dc_req_o !== 1'b1) begin errors++; $display("FAIL single_wait ack/req got %b/%b want 0/1", load_ack_o, dc_req_o); end
    tick(); dc_ack_i = 1; dc_rdata_i = 32'hDEADBEEF; look();
    checks++; if (load_ack_o !== 1'b1 || load_data_o !== 32'hDEADBEEF) begin errors++; $display("FAIL single_ack got %b/%h want 1/deadbeef", load_ack_o, load_data_o); end
    checks++; if (sb_store_ack_o !== 1'b0) begin errors++; $display("FAIL single_no_store_ack got %b want 0", sb_store_ack_o); end
    tick(); dc_ack_i = 0; load_req_i = 0; look();
    checks++; if (busy_o !== 1'b0 || dc_req_o !== 1'b0 || load_ack_o !== 1'b0) begin errors++; $display("FAIL single_idle busy/req/ack got %b%b%b want 000", busy_o, dc_req_o, load_ack_o); end
  endtask

  task automatic test_load_store_tie();
    apply_reset();
    load_req_i = 1; load_addr_i = 32'h300; load_size_i = HALF;
    sb_store_req_i = 1; sb_store_addr_i = 32'h400; sb_store_data_i = 32'hCAFEF00D; sb_store_size_i = BYTE;
    tick(); dc_ack_i = 1; dc_rdata_i = 32'h1111; look();
    checks++; if (dc_we_o !== 1'b0 || dc_addr_o !== 32'h300 || dc_size_o !== HALF) begin errors++; $display("FAIL tie_load_first we %b addr %h size %0d want 0/300/%0d", dc_we_o, dc_addr_o, dc_size_o, HALF); end
    checks++; if (load_ack_o !== 1'b1 || sb_store_ack_o !== 1'b0) begin errors++; $display("FAIL tie_load_ack got %b/%b want 1/0", load_ack_o, sb_store_ack_o); end
    tick(); dc_ack_i = 0; load_req_i = 0; look();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL tie_bubble busy got %b want 0", busy_o); end
    tick(); look();
    checks++; if (dc_req_o !== 1'b1 || dc_we_o !== 1'b1 || dc_addr_o !== 32'h400 || dc_wdata_o !== 32'hCAFEF00D || dc_size_o !== BYTE) begin errors++; $display("FAIL tie_store req %b we %b addr %h wdata %h size %0d want 1/1/400/cafef00d/%0d", dc_req_o, dc_we_o, dc_addr_o, dc_wdata_o, dc_size_o, BYTE); end
    tick(); dc_ack_i = 1; look();
    checks++; if (sb_store_ack_o !== 1'b1 || load_ack_o !== 1'b0) begin errors++; $display("FAIL tie_store_ack got %b/%b want 1/0", sb_store_ack_o, load_ack_o); end
    tick(); dc_ack_i = 0; sb_store_req_i = 0;
  endtask

  task automatic test_starvation();
    logic [AW-1:0] la;
    apply_reset();
    la = 32'h1000;
    load_req_i = 1; load_addr_i = la; load_size_i = WORD;
    sb_store_req_i = 1; sb_store_addr_i = 32'h200; sb_store_data_i = 32'h12345678; sb_store_size_i = WORD;
    for (int g = 0; g <= SL; g++) begin
      tick(); look();
      if (g == SL) begin
        checks++; if (dc_we_o !== 1'b1 || dc_addr_o !== 32'h200 || dc_wdata_o !== 32'h12345678) begin errors++; $display("FAIL starve_forced grant %0d we %b addr %h wdata %h want 1/200/12345678", g, dc_we_o, dc_addr_o, dc_wdata_o); end
      end else begin
        checks++; if (dc_we_o !== 1'b0 || dc_addr_o !== la) begin errors++; $display("FAIL starve_load grant %0d we %b addr %h want 0/%h", g, dc_we_o, dc_addr_o, la); end
      end
      tick(); dc_ack_i = 1; dc_rdata_i = 32'(g); look();
      tick(); dc_ack_i = 0;
      if (g == SL) sb_store_req_i = 0;
      else begin la = la + 4; load_addr_i = la; end
    end
    tick(); look();
    checks++; if (dc_we_o !== 1'b0 || dc_addr_o !== la) begin errors++; $display("FAIL starve_after we %b addr %h want 0/%h", dc_we_o, dc_addr_o, la); end
    tick(); dc_ack_i = 1; tick(); dc_ack_i = 0; load_req_i = 0;
  endtask

  task automatic test_override();
    for (int m = 0; m < 2; m++) begin
      apply_reset();
      load_req_i = 1; load_addr_i = 32'h600; load_size_i = WORD;
      sb_store_req_i = 1; sb_store_addr_i = 32'h700 + 32'(m); sb_store_data_i = 32'hBEEF0000 + 32'(m); sb_store_size_i = HALF;
      sb_full_i = (m == 0); sb_drain_i = (m == 1);
      tick(); look();
      checks++; if (dc_we_o !== 1'b1 || dc_addr_o !== 32'h700 + 32'(m)) begin errors++; $display("FAIL override_%0d we %b addr %h want 1/%h", m, dc_we_o, dc_addr_o, 32'h700 + 32'(m)); end
      tick(); dc_ack_i = 1; look();
      checks++; if (sb_store_ack_o !== 1'b1) begin errors++; $display("FAIL override_ack_%0d got %b want 1", m, sb_store_ack_o); end
      tick(); dc_ack_i = 0; sb_store_req_i = 0; sb_full_i = 0; sb_drain_i = 0;
      tick(); look();
      checks++; if (dc_we_o !== 1'b0 || dc_addr_o !== 32'h600 || dc_wdata_o !== 32'hBEEF0000 + 32'(m)) begin errors++; $display("FAIL override_then_load_%0d we %b addr %h wdata %h", m, dc_we_o, dc_addr_o, dc_wdata_o); end
      tick(); dc_ack_i = 1; tick(); dc_ack_i = 0; load_req_i = 0;
    end
  endtask

  task automatic test_reset_mid_store();
    apply_reset();
    sb_store_req_i = 1; sb_store_addr_i = 32'h240; sb_store_data_i = 32'hA5A5A5A5; sb_store_size_i = WORD;
    tick(); look();
    checks++; if (dc_req_o !== 1'b1 || dc_we_o !== 1'b1) begin errors++; $display("FAIL rstmid_busy req/we got %b/%b want 1/1", dc_req_o, dc_we_o); end
    rst_i = 0; dc_ack_i = 1; #1;
    checks++; if (dc_req_o !== 1'b0 || busy_o !== 1'b0 || sb_store_ack_o !== 1'b0) begin errors++; $display("FAIL rstmid_async req %b busy %b ack %b want 000", dc_req_o, busy_o, sb_store_ack_o); end
    tick(); dc_ack_i = 0; rst_i = 1; look();
    checks++; if (busy_o !== 1'b0 || sb_store_ack_o !== 1'b0) begin errors++; $display("FAIL rstmid_release busy %b ack %b want 00", busy_o, sb_store_ack_o); end
    tick(); look();
    checks++; if (dc_req_o !== 1'b1 || dc_we_o !== 1'b1 || dc_addr_o !== 32'h240 || dc_wdata_o !== 32'hA5A5A5A5) begin errors++; $display("FAIL rstmid_regrant req %b we %b addr %h wdata %h", dc_req_o, dc_we_o, dc_addr_o, dc_wdata_o); end
    tick(); dc_ack_i = 1; look();
    checks++; if (sb_store_ack_o !== 1'b1) begin errors++; $display("FAIL rstmid_ack got %b want 1", sb_store_ack_o); end
    tick(); dc_ack_i = 0; sb_store_req_i = 0;
  endtask

  task automatic test_idle_ack_and_payload();
    apply_reset();
    dc_ack_i = 1; dc_rdata_i = 32'h55; look();
    checks++; if (load_ack_o !== 1'b0 || sb_store_ack_o !== 1'b0) begin errors++; $display("FAIL idle_ack acks got %b%b want 00", load_ack_o, sb_store_ack_o); end
    tick(); look();
    checks++; if (busy_o !== 1'b0 || load_ack_o !== 1'b0) begin errors++; $display("FAIL idle_ack_stay busy %b ack %b want 00", busy_o, load_ack_o); end
    tick(); dc_ack_i = 0; load_req_i = 1; load_addr_i = 32'h500; load_size_i = HALF;
    tick(); load_addr_i = 32'h9999; load_size_i = BYTE; look();
    checks++; if (dc_addr_o !== 32'h500 || dc_size_o !== HALF || load_ack_o !== 1'b0) begin errors++; $display("FAIL payload_latched addr %h size %0d ack %b want 500/%0d/0", dc_addr_o, dc_size_o, load_ack_o, HALF); end
    tick(); look();
    checks++; if (dc_addr_o !== 32'h500) begin errors++; $display("FAIL payload_still addr %h want 500", dc_addr_o); end
    tick(); dc_ack_i = 1; dc_rdata_i = 32'h77; look();
    checks++; if (load_ack_o !== 1'b1 || load_data_o !== 32'h77 || dc_addr_o !== 32'h500) begin errors++; $display("FAIL payload_ack ack %b data %h addr %h want 1/77/500", load_ack_o, load_data_o, dc_addr_o); end
    tick(); dc_ack_i = 0; load_req_i = 0;
  endtask

  // Reference model: who owns the port, how many loads have overtaken the
  // waiting store, and what the dcache should currently be presented with.
  task automatic test_random(input int ncyc);
    int owner;
    int starve;
    logic m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    access_size_t m_size;
    logic e_lack, e_sack, drop_l, drop_s;
    int bad;
    owner = 0; starve = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_size = WORD;
    bad = 0;
    apply_reset();
    for (int c = 0; c < ncyc; c++) begin
      if (!load_req_i && $urandom_range(0, 2) == 0) begin
        load_req_i = 1; load_addr_i = $urandom; load_size_i = access_size_t'(2'($urandom_range(0, 2)));
      end
      if (!sb_store_req_i && $urandom_range(0, 3) == 0) begin
        sb_store_req_i = 1; sb_store_addr_i = $urandom; sb_store_data_i = $urandom;
        sb_store_size_i = access_size_t'(2'($urandom_range(0, 2)));
      end
      sb_full_i  = ($urandom_range(0, 7) == 0);
      sb_drain_i = ($urandom_range(0, 9) == 0);
      dc_ack_i   = ($urandom_range(0, 2) == 0);
      dc_rdata_i = $urandom;
      look();
      e_lack = (owner == 1) && dc_ack_i;
      e_sack = (owner == 2) && dc_ack_i;
      checks++;
      if (dc_req_o !== (owner != 0) || busy_o !== (owner != 0) || dc_we_o !== m_we ||
          dc_addr_o !== m_addr || dc_wdata_o !== m_wdata || dc_size_o !== m_size ||
          load_ack_o !== e_lack || sb_store_ack_o !== e_sack ||
          (e_lack && load_data_o !== dc_rdata_i)) begin
        errors++;
        if (bad < 10) $display("FAIL random cyc %0d req %b we %b addr %h wdata %h size %0d lack %b sack %b ldata %h / owner %0d we %b addr %h wdata %h size %0d lack %b sack %b rdata %h",
                               c, dc_req_o, dc_we_o, dc_addr_o, dc_wdata_o, dc_size_o, load_ack_o, sb_store_ack_o, load_data_o,
                               owner, m_we, m_addr, m_wdata, m_size, e_lack, e_sack, dc_rdata_i);
        bad++;
      end
      drop_l = e_lack;
      drop_s = e_sack;
      if (owner == 0) begin
        if (sb_store_req_i && (sb_full_i || sb_drain_i || starve >= SL || !load_req_i)) begin
          owner = 2; m_we = 1; m_addr = sb_store_addr_i; m_wdata = sb_store_data_i; m_size = sb_store_size_i;
          starve = 0;
        end else if (load_req_i) begin
          owner = 1; m_we = 0; m_addr = load_addr_i; m_size = load_size_i;
          if (sb_store_req_i) starve = (starve + 1 > SL) ? SL : starve + 1;
        end
      end else if (dc_ack_i) begin
        owner = 0;
      end
      tick();
      if (drop_l) load_req_i = 0;
      if (drop_s) sb_store_req_i = 0;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_load();
    test_load_store_tie();
    test_starvation();
    test_override();
    test_reset_mid_store();
    test_idle_ack_and_payload();
    test_random(800);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
